// File: rtl/chebyshev_desaturation.sv
// Sign-extends saturated O_BITS words back to WL through a 2-entry skid buffer with registered output.
// Optional saturation-event counter enabled by defining CHEB_SAT_COUNT_EN.
module chebyshev_desaturation #(
  parameter int WL                    = 12,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int CNT_W                 = 16,
  localparam int O_BITS = WL - (I_BITS - BOUNDARY_BIT_POSITION)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [O_BITS-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WL-1:0]     data_out,
  output logic              sat_hit,
  input  logic              sat_clr,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int EXT_W = WL - O_BITS;
  localparam logic [O_BITS-1:0] MAXP = {1'b0, {(O_BITS-1){1'b1}}};
  localparam logic [O_BITS-1:0] MAXN = {1'b1, {(O_BITS-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t            state, state_nxt;
  logic [WL-1:0]   head_data, skid_data;
  logic            head_sat, skid_sat;
  logic [WL-1:0]   in_ext;
  logic            in_sat;
  logic            push, pop;
  logic            head_ld_in, head_ld_skid, skid_ld;

  assign in_ext    = {{EXT_W{data_in[O_BITS-1]}}, data_in};
  assign in_sat    = (data_in == MAXP) || (data_in == MAXN);

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign data_out  = head_data;
  assign sat_hit   = head_sat && out_valid;

  // The head register is the output register; the skid entry only fills when the head is stalled.
  always_comb begin
    state_nxt    = state;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt  = ONE;
          head_ld_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_ld_in = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          skid_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt    = ONE;
          head_ld_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      head_sat  <= 1'b0;
      skid_data <= '0;
      skid_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (head_ld_in) begin
        head_data <= in_ext;
        head_sat  <= in_sat;
      end else if (head_ld_skid) begin
        head_data <= skid_data;
        head_sat  <= skid_sat;
      end
      if (skid_ld) begin
        skid_data <= in_ext;
        skid_sat  <= in_sat;
      end
    end
  end

`ifdef CHEB_SAT_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      cnt <= '0;
    end else if (push && in_sat && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat_count = cnt;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_chebyshev_desaturation.sv
// Directed + random bench for chebyshev_desaturation with a queue scoreboard.
// Counter checks follow CHEB_SAT_COUNT_EN when it is defined for the build.
module tb_chebyshev_desaturation;

  localparam int WL     = 12;
  localparam int O_BITS = 9;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [O_BITS-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [WL-1:0]     data_out;
  logic              sat_hit;
  logic              sat_clr;
  logic [CNT_W-1:0]  sat_count;

  chebyshev_desaturation #(
    .WL(WL),
    .I_BITS(6),
    .BOUNDARY_BIT_POSITION(3),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .sat_hit(sat_hit),
    .sat_clr(sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WL-1:0]    sb_d[$];
  logic             sb_s[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             stalled = 1'b0;
  logic [WL-1:0]    held_d;
  logic             held_s;
  logic             last_in_fire, last_out_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WL-1:0] ext_model(input logic [O_BITS-1:0] d);
    logic signed [O_BITS-1:0] s;
    s = d;
    return WL'(s);
  endfunction

  function automatic logic is_extreme(input logic [O_BITS-1:0] d);
    return (d == 9'h0FF) || (d == 9'h100);
  endfunction

  // Inputs are set right after a negedge; evaluation happens 1ns later, ends at next negedge.
  task automatic tick();
    logic infire, outfire;
    #1;
    infire  = in_valid && in_ready;
    outfire = out_valid && out_ready;
    if (rst) begin
      sb_d.delete();
      sb_s.delete();
      exp_cnt = '0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(data_out), 32'(held_d));
        chk("hold_sat", 32'(sat_hit), 32'(held_s));
      end
      if (outfire) begin
        if (sb_d.size() == 0) begin
          chk("unexpected_out", 32'(outfire), 32'd0);
        end else begin
          chk("sb_data", 32'(data_out), 32'(sb_d.pop_front()));
          chk("sb_sat", 32'(sat_hit), 32'(sb_s.pop_front()));
        end
      end
      if (infire) begin
        sb_d.push_back(ext_model(data_in));
        sb_s.push_back(is_extreme(data_in));
      end
`ifdef CHEB_SAT_COUNT_EN
      if (sat_clr) exp_cnt = '0;
      else if (infire && is_extreme(data_in) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      stalled = out_valid && !out_ready;
      held_d  = data_out;
      held_s  = sat_hit;
    end
    last_in_fire  = infire;
    last_out_fire = outfire;
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((sb_d.size() != 0) && (budget < 20)) begin
      tick();
      budget++;
    end
    chk("drain_empty", sb_d.size(), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int unsigned sent, cyc, outs;
    rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0; sat_clr = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_sat_hit", 32'(sat_hit), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);

    // Single extreme word, 1-cycle latency
    in_valid = 1'b1; data_in = 9'h0FF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(data_out), 32'h0FF);
    chk("t1_sat", 32'(sat_hit), 32'd1);
    tick();

    // Sign extension patterns streamed back to back
    in_valid = 1'b1;
    data_in = 9'h100; tick();
    chk("t2_maxn", 32'(data_out), 32'hF00);
    chk("t2_maxn_sat", 32'(sat_hit), 32'd1);
    data_in = 9'h1FE; tick();
    chk("t2_neg", 32'(data_out), 32'hFFE);
    chk("t2_neg_sat", 32'(sat_hit), 32'd0);
    data_in = 9'h045; tick();
    chk("t2_pos", 32'(data_out), 32'h045);
    chk("t2_pos_sat", 32'(sat_hit), 32'd0);
    drain();
    chk("t2_count", 32'(sat_count), 32'(exp_cnt));

    // Backpressure: buffer fills after two words
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 9'h011; tick();
    chk("t3_ready_after1", 32'(in_ready), 32'd1);
    data_in = 9'h022; tick();
    data_in = 9'h033;
    chk("t3_ready_full", 32'(in_ready), 32'd0);
    chk("t3_head", 32'(data_out), 32'h011);
    tick(); tick(); tick();
    chk("t3_ready_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    while (!last_in_fire && cyc < 10) begin tick(); cyc++; end
    chk("t3_033_taken", 32'(last_in_fire), 32'd1);
    drain();

    // Full throughput with continuous valid and ready
    outs = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = O_BITS'($urandom);
      tick();
      if (last_out_fire) outs++;
    end
    chk("t4_throughput", outs, 32'd19);
    drain();

    // Random valid/ready, 1000 words
    sent = 0; cyc = 0; in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!in_valid || last_in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        data_in  = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) != 0) ? 9'h0FF : 9'h100)
                                               : O_BITS'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_in_fire) sent++;
      cyc++;
    end
    chk("t4_sent", sent, 32'd1000);
    drain();
    chk("t4_count", 32'(sat_count), 32'(exp_cnt));

    // Reset with two words buffered discards them
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 9'h055; tick();
    data_in = 9'h0FF; tick();
    chk("t5_full", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_sat_count", 32'(sat_count), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_ghost", 32'(out_valid), 32'd0);
    end

    // Counter: 5 extremes among 10 words, clear priority, saturation
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = (i % 2 == 0) ? ((i % 4 == 0) ? 9'h0FF : 9'h100) : 9'h0A0 + O_BITS'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
`ifdef CHEB_SAT_COUNT_EN
    chk("t6_count5", 32'(sat_count), 32'd5);
    in_valid = 1'b1; data_in = 9'h100; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0; in_valid = 1'b0;
    chk("t6_clr_priority", 32'(sat_count), 32'd0);
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      data_in = i[0] ? 9'h100 : 9'h0FF;
      tick();
    end
    in_valid = 1'b0;
    chk("t6_saturated", 32'(sat_count), 32'h0000FFFF);
    tick();
    chk("t6_sat_hold", 32'(sat_count), 32'h0000FFFF);
`else
    chk("t6_count_off", 32'(sat_count), 32'd0);
    in_valid = 1'b1; data_in = 9'h100; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0; in_valid = 1'b0;
    chk("t6_count_off2", 32'(sat_count), 32'd0);
`endif
    chk("t6_model", 32'(sat_count), 32'(exp_cnt));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
